// File: rtl/sync_mod_counter.sv
// Modulo-N synchronous up/down counter with load, clear, terminal count and wrap pulse.
// Define MODCNT_CASCADE_EN to add cin/cout ports for chaining stages into wider counters.
module sync_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MODCNT_CASCADE_EN
    input  logic             cin,
    output logic             cout,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qnot,
    output logic             tc,
    output logic             wrap
);

    // One spare bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0]   q_x;
    logic [WIDTH:0]   ld_x;
    logic [WIDTH:0]   ld_sel_x;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH-1:0] ld_q;
    logic [WIDTH-1:0] cnt_q;
    logic             at_max;
    logic             at_zero;
    logic             step;
    logic [1:0]       unused_msb;

    assign q_x     = {1'b0, Q};
    assign ld_x    = {1'b0, load_val};
    assign at_max  = (q_x == MAX_X);
    assign at_zero = (q_x == '0);

    assign tc   = up_dn ? at_max : at_zero;
    assign Qnot = ~Q;

`ifdef MODCNT_CASCADE_EN
    assign step = en & cin;
    assign cout = tc & en & cin;
`else
    assign step = en;
`endif

    // Next-state candidates: clamped load value and modulo step.
    always_comb begin
        ld_sel_x = MAX_X;
        cnt_x    = q_x;
        if (ld_x < MOD_X) begin
            ld_sel_x = ld_x;
        end
        if (up_dn) begin
            cnt_x = at_max ? '0 : q_x + 1'b1;
        end else begin
            cnt_x = at_zero ? MAX_X : q_x - 1'b1;
        end
    end

    // Top bit is always zero once values are back in range.
    assign ld_q       = ld_sel_x[WIDTH-1:0];
    assign cnt_q      = cnt_x[WIDTH-1:0];
    assign unused_msb = {ld_sel_x[WIDTH], cnt_x[WIDTH]};

    // Counter register: reset > clr > load > count > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            Q    <= ld_q;
            wrap <= 1'b0;
        end else if (step) begin
            Q    <= cnt_q;
            wrap <= tc;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed bench for sync_mod_counter: vector table, binary-modulus
// corner, and a two-stage BCD chain built from en/tc.
module tb_sync_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main DUT, WIDTH=4 MODULUS=10
    logic       reset, en, up_dn, clr, load;
    logic [3:0] load_val, q, qn;
    logic       tc, wrap;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn),
        .clr(clr), .load(load), .load_val(load_val),
        .Q(q), .Qnot(qn), .tc(tc), .wrap(wrap)
    );

    // Binary modulus instance, MODULUS = 2**WIDTH
    logic       b_rst, b_en, b_up, b_ld;
    logic [3:0] b_lv, b_q, b_qn;
    logic       b_tc, b_wrap;

    sync_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_bin (
        .clk(clk), .reset(b_rst), .en(b_en), .up_dn(b_up),
        .clr(1'b0), .load(b_ld), .load_val(b_lv),
        .Q(b_q), .Qnot(b_qn), .tc(b_tc), .wrap(b_wrap)
    );

    // Two-stage BCD chain: stage1 steps when stage0 is at terminal count
    logic       c_rst, c_en, c1_en;
    logic [3:0] c0_q, c0_qn, c1_q, c1_qn;
    logic       c0_tc, c1_tc, c0_wr, c1_wr;

    assign c1_en = c0_tc & c_en;

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) c0 (
        .clk(clk), .reset(c_rst), .en(c_en), .up_dn(1'b1),
        .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .Q(c0_q), .Qnot(c0_qn), .tc(c0_tc), .wrap(c0_wr)
    );

    sync_mod_counter #(.WIDTH(4), .MODULUS(10)) c1 (
        .clk(clk), .reset(c_rst), .en(c1_en), .up_dn(1'b1),
        .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .Q(c1_q), .Qnot(c1_qn), .tc(c1_tc), .wrap(c1_wr)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic [3:0] eq;
        logic       etc;
        logic       ewr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic rst, input logic e, input logic u,
        input logic c, input logic l, input logic [3:0] lv,
        input logic [3:0] eq, input logic etc, input logic ewr
    );
        vec_t v;
        v.rst = rst; v.en = e; v.up = u; v.clr = c; v.ld = l;
        v.lv = lv; v.eq = eq; v.etc = etc; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk4(input string nm, input logic [3:0] act,
                        input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        reset = 0; en = 0; up_dn = 0; clr = 0; load = 0; load_val = 0;
        b_rst = 1; b_en = 0; b_up = 1; b_ld = 0; b_lv = 0;
        c_rst = 1; c_en = 0;

        //         rst en up clr ld lv    Q   tc  wr
        // reset, down direction -> tc=1
        tv.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 1, 0));
        // count up 12 from 0
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd3, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd4, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd5, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd6, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd7, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd8, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd9, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 1));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd2, 0, 0));
        // load 1, then count down 3
        tv.push_back(mk(0, 0, 0, 0, 1, 4'd1, 4'd1, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 4'd0, 4'd0, 1, 0));
        tv.push_back(mk(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 1));
        tv.push_back(mk(0, 1, 0, 0, 0, 4'd0, 4'd8, 0, 0));
        // load out of range clamps, clr beats load, reset with clr
        tv.push_back(mk(0, 0, 0, 0, 1, 4'd13, 4'd9, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 1, 4'd5, 4'd0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 4'd7, 4'd7, 0, 0));
        tv.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 1, 0));
        // load boundaries, load beats count
        tv.push_back(mk(0, 0, 1, 0, 1, 4'd10, 4'd9, 1, 0));
        tv.push_back(mk(0, 0, 1, 0, 1, 4'd15, 4'd9, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 1, 4'd5, 4'd5, 0, 0));
        // hold with direction toggling
        tv.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0));
        // wrap then hold clears wrap
        tv.push_back(mk(0, 0, 1, 0, 1, 4'd9, 4'd9, 1, 0));
        tv.push_back(mk(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 1));
        tv.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0));
        // reset at terminal count while counting: no wrap
        tv.push_back(mk(0, 0, 1, 0, 1, 4'd9, 4'd9, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0));
        // clr at terminal count (down at 0) while counting: no wrap
        tv.push_back(mk(0, 1, 0, 1, 0, 4'd0, 4'd0, 1, 0));
        // down wrap pulse from 0 after clr
        tv.push_back(mk(0, 1, 0, 0, 0, 4'd0, 4'd9, 0, 1));
        // tc follows up_dn immediately, no edge needed: count hold at 9
        tv.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd9, 1, 0));

        foreach (tv[i]) begin
            reset    = tv[i].rst;
            en       = tv[i].en;
            up_dn    = tv[i].up;
            clr      = tv[i].clr;
            load     = tv[i].ld;
            load_val = tv[i].lv;
            @(posedge clk);
            #1;
            chk4($sformatf("v%0d.Q", i), q, tv[i].eq);
            chk4($sformatf("v%0d.Qnot", i), qn, ~tv[i].eq);
            chk1($sformatf("v%0d.tc", i), tc, tv[i].etc);
            chk1($sformatf("v%0d.wrap", i), wrap, tv[i].ewr);
        end

        // tc combinational on up_dn at Q=9
        reset = 0; en = 0; clr = 0; load = 0;
        up_dn = 0;
        #1;
        chk1("tc_dir_dn", tc, 1'b0);
        up_dn = 1;
        #1;
        chk1("tc_dir_up", tc, 1'b1);

        // Binary modulus 16
        @(posedge clk); #1;
        b_rst = 0; b_ld = 1; b_lv = 4'd14;
        @(posedge clk); #1;
        chk4("bin.load14", b_q, 4'd14);
        b_ld = 0; b_en = 1; b_up = 1;
        @(posedge clk); #1;
        chk4("bin.q15", b_q, 4'd15);
        chk1("bin.tc15", b_tc, 1'b1);
        @(posedge clk); #1;
        chk4("bin.q0", b_q, 4'd0);
        chk1("bin.wrap_up", b_wrap, 1'b1);
        b_up = 0;
        @(posedge clk); #1;
        chk4("bin.q15dn", b_q, 4'd15);
        chk1("bin.wrap_dn", b_wrap, 1'b1);
        chk4("bin.qnot", b_qn, 4'd0);
        b_en = 0;

        // Two-stage BCD chain 00..99 then 00
        @(posedge clk); #1;
        c_rst = 0; c_en = 1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            chk4($sformatf("bcd%0d.lo", k), c0_q, 4'((k % 100) % 10));
            chk4($sformatf("bcd%0d.hi", k), c1_q, 4'((k % 100) / 10));
        end
        chk1("bcd.hi_wrap", c1_wr, 1'b1);
        c_en = 0;
        @(posedge clk); #1;
        chk1("bcd.hi_wrap_clr", c1_wr, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
